// File: rtl/color_proc_thr.sv
// Frame-sequenced colour threshold processor: reads an RGB frame, applies per-channel windows, writes the processed frame.
// Optional bounding-box statistics are compiled in with `define COLOR_PROC_BBOX_EN.
module color_proc_thr #(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_img_pxls     = c_img_cols * c_img_rows,
    parameter int c_nb_img_pxls  = 13,
    parameter int c_nb_buf_red   = 4,
    parameter int c_nb_buf_green = 4,
    parameter int c_nb_buf_blue  = 4,
    parameter int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue,
    parameter int c_mem_lat      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     proc_ctrl,
    input  logic [2:0]               chan_mask,
    input  logic [c_nb_buf-1:0]      thr_min,
    input  logic [c_nb_buf-1:0]      thr_max,
    input  logic [c_nb_buf-1:0]      orig_pxl,
    output logic [c_nb_img_pxls-1:0] orig_addr,
    output logic                     proc_we,
    output logic [c_nb_buf-1:0]      proc_pxl,
    output logic [c_nb_img_pxls-1:0] proc_addr,
    output logic [1:0]               mode,
    output logic                     busy,
    output logic                     frame_done,
    output logic [c_nb_img_pxls-1:0] match_cnt
`ifdef COLOR_PROC_BBOX_EN
   ,output logic                             bbox_valid,
    output logic [$clog2(c_img_cols)-1:0]    bbox_col_min,
    output logic [$clog2(c_img_cols)-1:0]    bbox_col_max,
    output logic [$clog2(c_img_rows)-1:0]    bbox_row_min,
    output logic [$clog2(c_img_rows)-1:0]    bbox_row_max
`endif
);

    typedef enum logic [1:0] {st_idle, st_run, st_drain} state_t;
    typedef enum logic [1:0] {m_pass = 2'd0, m_keep = 2'd1, m_bin = 2'd2} mode_t;

    localparam logic [c_nb_img_pxls-1:0] last_pxl = c_nb_img_pxls'(c_img_pxls - 1);
    localparam logic [c_nb_img_pxls-1:0] n_pxls   = c_nb_img_pxls'(c_img_pxls);

    state_t                     state, state_nxt;
    mode_t                      act_mode, pend_mode;
    logic                       frame_start;
    logic                       last_wr;
    logic [c_nb_img_pxls-1:0]   cnt;
    logic [c_nb_img_pxls-1:0]   acc;
    logic [2:0]                 mask_q;
    logic [c_nb_buf-1:0]        min_q, max_q;
    logic [2:0]                 ctrl_sync;
    logic                       ctrl_rise;
    logic [c_mem_lat-1:0]       dl_vld;
    logic [c_nb_img_pxls-1:0]   dl_addr [c_mem_lat];
    logic                       px_vld;
    logic [c_nb_img_pxls-1:0]   px_addr;
    logic                       in_r, in_g, in_b, match;
    logic [c_nb_buf-1:0]        pxl_out;

    assign ctrl_rise = ctrl_sync[1] & ~ctrl_sync[2];
    assign last_wr   = proc_we && (proc_addr == last_pxl);
    assign px_vld    = dl_vld[c_mem_lat-1];
    assign px_addr   = dl_addr[c_mem_lat-1];
    assign orig_addr = cnt;
    assign mode      = act_mode;
    assign busy      = (state != st_idle);

    // Unsigned per-channel window tests; an empty window (min > max) can never pass.
    assign in_r = (orig_pxl[c_nb_buf-1 -: c_nb_buf_red] >= min_q[c_nb_buf-1 -: c_nb_buf_red]) &&
                  (orig_pxl[c_nb_buf-1 -: c_nb_buf_red] <= max_q[c_nb_buf-1 -: c_nb_buf_red]);
    assign in_g = (orig_pxl[c_nb_buf_blue +: c_nb_buf_green] >= min_q[c_nb_buf_blue +: c_nb_buf_green]) &&
                  (orig_pxl[c_nb_buf_blue +: c_nb_buf_green] <= max_q[c_nb_buf_blue +: c_nb_buf_green]);
    assign in_b = (orig_pxl[0 +: c_nb_buf_blue] >= min_q[0 +: c_nb_buf_blue]) &&
                  (orig_pxl[0 +: c_nb_buf_blue] <= max_q[0 +: c_nb_buf_blue]);
    assign match = (!mask_q[2] || in_r) && (!mask_q[1] || in_g) && (!mask_q[0] || in_b);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pxl_out = orig_pxl;
        case (act_mode)
            m_keep:  pxl_out = match ? orig_pxl : '0;
            m_bin:   pxl_out = match ? '1 : '0;
            default: pxl_out = orig_pxl;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        case (state)
            st_idle: begin
                if (run) begin
                    state_nxt   = st_run;
                    frame_start = 1'b1;
                end
            end
            st_run: begin
                if (cnt == last_pxl) state_nxt = st_drain;
            end
            st_drain: begin
                if (last_wr) begin
                    state_nxt   = run ? st_run : st_idle;
                    frame_start = run;
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= st_idle;
            act_mode   <= m_pass;
            pend_mode  <= m_pass;
            ctrl_sync  <= '0;
            cnt        <= '0;
            acc        <= '0;
            mask_q     <= '0;
            min_q      <= '0;
            max_q      <= '0;
            dl_vld     <= '0;
            proc_we    <= 1'b0;
            proc_pxl   <= '0;
            proc_addr  <= '0;
            frame_done <= 1'b0;
            match_cnt  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state     <= state_nxt;
            ctrl_sync <= {ctrl_sync[1:0], proc_ctrl};
            if (ctrl_rise) begin
                case (pend_mode)
                    m_pass:  pend_mode <= m_keep;
                    m_keep:  pend_mode <= m_bin;
                    default: pend_mode <= m_pass;
                endcase
            end

            frame_done <= (state == st_drain) && last_wr;
            if ((state == st_drain) && last_wr) match_cnt <= acc;

            if (frame_start) begin
                act_mode <= pend_mode;
                mask_q   <= chan_mask;
                min_q    <= thr_min;
                max_q    <= thr_max;
                cnt      <= '0;
                acc      <= '0;
            end else begin
                if ((state == st_run) && (cnt != last_pxl)) cnt <= cnt + 1'b1;
                if (px_vld && match && (acc != n_pxls)) acc <= acc + 1'b1;
            end

            dl_vld[0] <= (state == st_run);
            for (int i = 1; i < c_mem_lat; i++) dl_vld[i] <= dl_vld[i-1];

            proc_we <= px_vld;
            if (px_vld) begin
                proc_addr <= px_addr;
                proc_pxl  <= pxl_out;
            end
        end
    end

    // NOTE: the address delay line is left without reset; its entries are only used when qualified by dl_vld.
    always_ff @(posedge clk) begin
        dl_addr[0] <= cnt;
        for (int i = 1; i < c_mem_lat; i++) dl_addr[i] <= dl_addr[i-1];
    end

`ifdef COLOR_PROC_BBOX_EN
    localparam int c_nb_col = $clog2(c_img_cols);
    localparam int c_nb_row = $clog2(c_img_rows);

    logic [c_nb_col-1:0] col, cmin, cmax;
    logic [c_nb_row-1:0] row, rmin, rmax;

    // Row/column of the pixel currently at the processing stage, tracked alongside px_addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            row          <= '0;
            cmin         <= '0;
            cmax         <= '0;
            rmin         <= '0;
            rmax         <= '0;
            bbox_valid   <= 1'b0;
            bbox_col_min <= '0;
            bbox_col_max <= '0;
            bbox_row_min <= '0;
            bbox_row_max <= '0;
        end else begin
            if (frame_start) begin
                col  <= '0;
                row  <= '0;
                cmin <= c_nb_col'(c_img_cols - 1);
                cmax <= '0;
                rmin <= c_nb_row'(c_img_rows - 1);
                rmax <= '0;
            end else if (px_vld) begin
                if (col == c_nb_col'(c_img_cols - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (match) begin
                    if (col < cmin) cmin <= col;
                    if (col > cmax) cmax <= col;
                    if (row < rmin) rmin <= row;
                    if (row > rmax) rmax <= row;
                end
            end
            if ((state == st_drain) && last_wr) begin
                bbox_valid   <= (acc != '0);
                bbox_col_min <= (acc != '0) ? cmin : '0;
                bbox_col_max <= (acc != '0) ? cmax : '0;
                bbox_row_min <= (acc != '0) ? rmin : '0;
                bbox_row_max <= (acc != '0) ? rmax : '0;
            end
        end
    end
`endif

endmodule

// File: doc/color_proc_thr.md
Name: color_proc_thr

Overview:
Frame-sequenced colour threshold processor. It reads an RGB frame buffer pixel by pixel and applies a per-channel min/max window. Each pixel is either passed through, kept/blacked, or binarised, and the result is written to the processed-frame buffer. It sits between the camera capture buffer and the VGA display buffer, adds frame-granular run control and per-frame match statistics, and supports a configurable memory read latency.

Parameters:
c_img_cols, 80, image width in pixels
c_img_rows, 60, image height in pixels
c_img_pxls, c_img_cols*c_img_rows, pixels per frame
c_nb_img_pxls, 13, address/counter width; c_img_pxls <= 2^c_nb_img_pxls - 1
c_nb_buf_red, 4, red bits per pixel
c_nb_buf_green, 4, green bits per pixel
c_nb_buf_blue, 4, blue bits per pixel
c_nb_buf, sum of the three, pixel word width, packed {R,G,B} with R in the MSBs
c_mem_lat, 1, source memory read latency in cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
run  in  1  level; 1 = process frames continuously, 0 = stop at end of current frame
proc_ctrl  in  1  button; each rising edge advances the pending mode
chan_mask  in  3  {R,G,B}; channels that must lie inside their window
thr_min  in  c_nb_buf  packed per-channel lower bounds (inclusive)
thr_max  in  c_nb_buf  packed per-channel upper bounds (inclusive)
orig_pxl  in  c_nb_buf  source pixel data
orig_addr  out  c_nb_img_pxls  source read address
proc_we  out  1  write enable to processed buffer
proc_pxl  out  c_nb_buf  processed pixel
proc_addr  out  c_nb_img_pxls  processed pixel address
mode  out  2  mode active in current frame: 0 PASS, 1 KEEP, 2 BIN
busy  out  1  high in RUN and DRAIN
frame_done  out  1  one-cycle pulse after last write of a frame
match_cnt  out  c_nb_img_pxls  matched pixels in last completed frame

Behaviour:
- Reset: all outputs 0, FSM IDLE, active and pending mode PASS, counters 0.
- proc_ctrl: two-flop synchroniser, then rising-edge detect. Each pulse advances pending mode PASS->KEEP->BIN->PASS. Two pulses in one frame advance it twice.
- FSM IDLE: run=1 -> RUN.
- On entry to RUN (frame start):
  - latch pending mode into mode;
  - latch chan_mask, thr_min, thr_max into internal registers;
  - clear pixel counter and match accumulator.
- Mid-frame changes to these inputs have no effect until the next frame.
- RUN: orig_addr = pixel counter, incremented every cycle. When the counter equals c_img_pxls-1, go to DRAIN. The counter does not wrap within RUN.
- DRAIN: wait until the last pixel has been written (c_mem_lat+1 cycles after the last address). Then pulse frame_done, load match_cnt from the accumulator, and go to RUN (new frame start) if run=1, otherwise IDLE.
- run falling mid-frame: the frame completes normally. run is sampled only in DRAIN and IDLE.
- Pipeline: address issued at cycle t; orig_pxl valid at t+c_mem_lat; proc_pxl, proc_addr and proc_we registered at t+c_mem_lat+1.
  - proc_we is high exactly c_img_pxls cycles per frame, otherwise 0.
  - Address and valid are carried in a delay line of depth c_mem_lat.
- Match: a channel is in window if thr_min_ch <= value <= thr_max_ch (unsigned).
  - match = AND of in-window results over the channels set in chan_mask.
  - chan_mask=000 -> every pixel matches.
  - thr_min_ch > thr_max_ch -> that channel never matches.
- Output pixel:
  - PASS: orig_pxl.
  - KEEP: match ? orig_pxl : 0.
  - BIN: match ? all-ones : 0.
- match_cnt counts matches in every mode, including PASS. The accumulator increments on each proc_we with match and saturates at c_img_pxls.
- Async reset mid-frame aborts immediately to IDLE; outputs go to reset values with no frame_done pulse.

Optional Feature:
COLOR_PROC_BBOX_EN.
- Defined: adds outputs bbox_valid (1), bbox_col_min/bbox_col_max (7), bbox_row_min/bbox_row_max (6).
  - Widths are log2 of c_img_cols and c_img_rows.
  - Row/col are tracked by counters alongside proc_addr.
  - The box of matched pixels updates at frame_done.
  - bbox_valid=0 if match_cnt=0; all outputs are 0 on reset.
- Undefined: these ports and logic are absent; other behaviour is identical.

Test Plan:
- Reset, run=1, mode PASS, memory holds addr-based pattern, c_mem_lat=1 -> first proc_we 2 cycles after first orig_addr; proc_pxl equals memory at proc_addr for all 4800 writes; frame_done after write of address 4799.
- One proc_ctrl pulse mid-frame -> mode stays 0 for rest of frame, becomes 1 at next frame start.
- KEEP, chan_mask=100, thr R 8..15, image half R=0xC and half R=0x3 -> those pixels pass and the R=0x3 pixels write 0; match_cnt=2400.
- BIN, chan_mask=111, thr_min=0x888, thr_max=0xFFF, pixel 0x9A8 -> 0xFFF; pixel 0x9A7 -> 0x000.
- run dropped at address 100 -> remaining 4699 pixels written, frame_done, then busy=0 and no further proc_we; rst asserted mid-frame -> outputs 0 at once, no frame_done.
- c_mem_lat=3 -> proc_we lags orig_addr by 4 cycles; data/address alignment preserved; with COLOR_PROC_BBOX_EN, a single matched pixel at (col 10, row 5) gives bbox 10..10 × 5..5 and bbox_valid=1.
